// File: rtl/uart_transmit_io_if.sv
// Store-port side of the UART transmitter: byte write strobe in, FIFO status out.
// The master is the memory stage driving stores; the slave is the transmitter.
interface uart_transmit_io_if;
  logic       write_strobe;
  logic [7:0] write_data;
  logic       clear_overflow;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  modport master (
    output write_strobe,
    output write_data,
    output clear_overflow,
    input  fifo_full,
    input  fifo_empty,
    input  overflow
  );

  modport slave (
    input  write_strobe,
    input  write_data,
    input  clear_overflow,
    output fifo_full,
    output fifo_empty,
    output overflow
  );
endinterface

// File: rtl/uart_transmit_io.sv
// Memory-mapped UART transmitter: byte FIFO fed by store strobes, drained as 8N1 frames
// (LSB first) by a registered-output TX state machine.
module uart_transmit_io #(
  parameter int unsigned CLOCKS_PER_BIT  = 104,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_transmit_io_if.slave  bus,
  output logic               tx,
  output logic               tx_busy
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned BaudW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;
  typedef logic [BaudW-1:0]           baud_t;

  localparam cnt_t  DepthCnt = cnt_t'(Depth);
  localparam baud_t BaudLast = baud_t'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO state
  logic [7:0] mem_q [Depth];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       overflow_q, overflow_d;
  logic       push, pop;

  // TX state
  state_e     state_q, state_d;
  baud_t      baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       baud_end;
  logic       fifo_has_data;

  assign baud_end      = (baud_q == BaudLast);
  assign fifo_has_data = (count_q != '0);

  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push = bus.write_strobe && ((count_q != DepthCnt) || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);

    // A dropped write beats a simultaneous clear.
    overflow_d = overflow_q;
    if (bus.write_strobe && !push) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.write_data;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_has_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + baud_t'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q + baud_t'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (fifo_has_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + baud_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; tx is computed from the next state so the line is a clean flop output
  always_comb begin
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx             = tx_q;
  assign tx_busy        = (state_q != StIdle);
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_transmit_io.sv
// Directed bench for uart_transmit_io: stimulus queues expected bytes, a serial monitor
// decodes frames off tx and checks them against the queue.
module tb_uart_transmit_io;

  localparam int unsigned Cpb         = 4;
  localparam int unsigned FrameCycles = 10 * Cpb;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tx;
  logic tx_busy;

  uart_transmit_io_if bus ();

  uart_transmit_io #(
    .CLOCKS_PER_BIT (Cpb),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int          frames_done = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.write_strobe = 1'b1;
    bus.write_data   = b;
    tick();
    bus.write_strobe = 1'b0;
    bus.write_data   = 8'hEE;
  endtask

  task automatic drain(input string name, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_bit(name, done, 1'b1);
  endtask

  // Serial monitor: samples tx every cycle, decodes one 8N1 frame per start bit.
  initial begin : monitor
    logic [FrameCycles-1:0] smp;
    logic [7:0]             data;
    logic                   wf;
    logic                   aborted;
    int unsigned            t0;
    forever begin
      @(negedge clk);
      if (reset_n && tx === 1'b0) begin
        t0      = cyc;
        aborted = 1'b0;
        smp     = '0;
        smp[0]  = tx;
        for (int k = 1; k < FrameCycles; k++) begin
          @(negedge clk);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          smp[k] = tx;
        end
        if (!aborted) begin
          wf = 1'b1;
          for (int b = 0; b < 10; b++) begin
            for (int s = 1; s < Cpb; s++) begin
              if (smp[b*Cpb+s] !== smp[b*Cpb]) wf = 1'b0;
            end
          end
          if (smp[0] !== 1'b0 || smp[9*Cpb] !== 1'b1) wf = 1'b0;
          for (int b = 0; b < 8; b++) data[b] = smp[(b+1)*Cpb];
          check_bit("frame_shape", wf, 1'b1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_unexpected: got 0x%0h expected no frame", data);
          end else begin
            check_val("frame_data", int'(data), int'(exp_q.pop_front()));
          end
          start_q.push_back(t0);
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int unsigned e0;
    int          s;
    int          fd;

    bus.write_strobe   = 1'b0;
    bus.write_data     = 8'h00;
    bus.clear_overflow = 1'b0;
    repeat (3) tick();

    // Reset state
    check_bit("rst_tx", tx, 1'b1);
    check_bit("rst_empty", bus.fifo_empty, 1'b1);
    check_bit("rst_full", bus.fifo_full, 1'b0);
    check_bit("rst_busy", tx_busy, 1'b0);
    check_bit("rst_overflow", bus.overflow, 1'b0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single byte 0x55: start bit one cycle after the push, busy for exactly one frame
    exp_q.push_back(8'h55);
    s = start_q.size();
    strobe(8'h55);
    e0 = cyc;
    check_bit("single_e0_tx", tx, 1'b1);
    check_bit("single_e0_empty", bus.fifo_empty, 1'b0);
    check_bit("single_e0_busy", tx_busy, 1'b0);
    tick();
    check_bit("single_e1_tx", tx, 1'b0);
    check_bit("single_e1_busy", tx_busy, 1'b1);
    check_bit("single_e1_empty", bus.fifo_empty, 1'b1);
    repeat (FrameCycles - 1) tick();
    check_bit("single_last_busy", tx_busy, 1'b1);
    tick();
    check_bit("single_done_busy", tx_busy, 1'b0);
    check_bit("single_done_tx", tx, 1'b1);
    drain("single_drain", 50);
    check_val("single_frames", start_q.size() - s, 1);
    if (start_q.size() > s) check_val("single_latency", int'(start_q[s] - e0), 1);

    // Back-to-back 0xA3, 0x0F: no idle gap between frames
    repeat (3) tick();
    s = start_q.size();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    strobe(8'hA3);
    strobe(8'h0F);
    drain("b2b_drain", 200);
    check_val("b2b_frames", start_q.size() - s, 2);
    if (start_q.size() > s + 1) begin
      check_val("b2b_gap", int'(start_q[s+1] - start_q[s]), FrameCycles);
    end

    // Overflow: 0x01 goes to the shifter, 0x02..0x05 fill the FIFO, 0x06 is dropped
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) strobe(8'(i));
    check_bit("ovf_set", bus.overflow, 1'b1);
    check_bit("ovf_full", bus.fifo_full, 1'b1);
    // Clear and a dropped write on the same edge: set wins
    bus.clear_overflow = 1'b1;
    strobe(8'h66);
    bus.clear_overflow = 1'b0;
    check_bit("ovf_clear_vs_drop", bus.overflow, 1'b1);
    check_bit("ovf_still_full", bus.fifo_full, 1'b1);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    check_bit("ovf_cleared", bus.overflow, 1'b0);
    // Now at E7; the first frame's stop bit ends on E41, which also pops 0x02
    repeat (33) tick();
    check_bit("pop_pre_full", bus.fifo_full, 1'b1);
    check_bit("pop_pre_tx", tx, 1'b1);
    exp_q.push_back(8'h77);
    strobe(8'h77);
    check_bit("pop_push_ovf", bus.overflow, 1'b0);
    check_bit("pop_push_full", bus.fifo_full, 1'b1);
    check_bit("pop_next_start", tx, 1'b0);
    drain("ovf_drain", 400);
    check_bit("ovf_end_empty", bus.fifo_empty, 1'b1);
    check_bit("ovf_end_full", bus.fifo_full, 1'b0);

    // Reset during data bit 3 of 0x11 with 0x22 and 0x33 queued
    repeat (3) tick();
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    repeat (16) tick();
    check_bit("mid_bit3", tx, 1'b0);
    check_bit("mid_busy", tx_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_bit("mid_rst_tx", tx, 1'b1);
    check_bit("mid_rst_empty", bus.fifo_empty, 1'b1);
    check_bit("mid_rst_busy", tx_busy, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    fd = frames_done;
    repeat (100) tick();
    check_val("mid_no_frames", frames_done, fd);
    check_bit("mid_idle_tx", tx, 1'b1);
    check_bit("mid_idle_busy", tx_busy, 1'b0);
    check_bit("mid_idle_empty", bus.fifo_empty, 1'b1);
    check_val("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
